// File: rtl/mio_wait_target_if.sv
// MIO bus bundle between the multi-cycle CPU (master) and a memory-mapped target (slave).
// Carries the request/ready handshake, address and data, and the timer interrupt pair.
interface mio_wait_target_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              CPU_MIO;
    logic              mem_w;
    logic [ADDR_W-1:0] Addr_out;
    logic [DATA_W-1:0] Data_out;
    logic [DATA_W-1:0] Data_in;
    logic              MIO_ready;
    logic              bus_err;
    logic              INT;
    logic              int_ack;

    modport master (
        output CPU_MIO, mem_w, Addr_out, Data_out, int_ack,
        input  Data_in, MIO_ready, bus_err, INT
    );

    modport slave (
        input  CPU_MIO, mem_w, Addr_out, Data_out, int_ack,
        output Data_in, MIO_ready, bus_err, INT
    );
endinterface

// File: rtl/mio_wait_target.sv
// MIO bus target: word RAM plus periodic interrupt timer, answering each request after
// WAIT_CYCLES wait states with a one-cycle MIO_ready pulse.
module mio_wait_target #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2,
    parameter int TIMER_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    mio_wait_target_if.slave bus
);
    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int WCNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int OFF_W  = ADDR_W - 6;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_HOLD} state_t;

    state_t              state;
    logic [WCNT_W-1:0]   wait_cnt;
    logic [ADDR_W-1:2]   lat_addr;
    logic [DATA_W-1:0]   lat_data;
    logic                lat_we;

    logic [TIMER_W-1:0]  period;
    logic [TIMER_W-1:0]  count;
    logic                enable;

    logic                ready_q;
    logic                err_q;
    logic                irq_q;
    logic [DATA_W-1:0]   rdata_q;

    logic [DATA_W-1:0]   ram [DEPTH];

    logic                tmr_sel;
    logic                ram_sel;
    logic                sel_period;
    logic                sel_ctrl;
    logic                sel_count;
    logic                mapped;
    logic [OFF_W-1:0]    tmr_off;
    logic [DEPTH_LOG2-1:0] ram_idx;
    logic                resp_wr;
    logic                ram_we;
    logic                tmr_wr;
    logic                running;
    logic                wrap;
    logic [DATA_W-1:0]   rd_data;

    // Decode works on the latched request so the CPU may change its outputs after acceptance.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        rd_data    = '0;
        tmr_sel    = (lat_addr[ADDR_W-1:ADDR_W-4] == 4'hF);
        tmr_off    = lat_addr[ADDR_W-5:2];
        ram_idx    = lat_addr[DEPTH_LOG2+1:2];
        ram_sel    = (lat_addr[ADDR_W-1:DEPTH_LOG2+2] == '0);
        sel_period = tmr_sel && (tmr_off == OFF_W'(0));
        sel_ctrl   = tmr_sel && (tmr_off == OFF_W'(1));
        sel_count  = tmr_sel && (tmr_off == OFF_W'(2));
        mapped     = ram_sel || sel_period || sel_ctrl || sel_count;
        resp_wr    = (state == S_RESP) && lat_we;
        ram_we     = reset && resp_wr && ram_sel;
        tmr_wr     = resp_wr && tmr_sel;
        running    = enable && (period != '0);
        wrap       = running && (count == period - TIMER_W'(1));

        if (ram_sel)         rd_data = ram[ram_idx];
        else if (sel_period) rd_data = DATA_W'(period);
        else if (sel_ctrl)   rd_data = DATA_W'(enable);
        else if (sel_count)  rd_data = DATA_W'(count);
    end

    // Request capture is pure datapath; its contents only matter once the FSM leaves IDLE.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && bus.CPU_MIO) begin
            lat_addr <= bus.Addr_out[ADDR_W-1:2];
            lat_data <= bus.Data_out;
            lat_we   <= bus.mem_w;
        end
    end

    // NOTE: the RAM has no reset so it maps onto memory primitives; contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_idx] <= lat_data;
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
            period   <= '0;
            enable   <= 1'b0;
            count    <= '0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (bus.CPU_MIO) begin
                        wait_cnt <= WCNT_W'(WAIT_CYCLES);
                        state    <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - WCNT_W'(1);
                    if (wait_cnt == WCNT_W'(1)) state <= S_RESP;
                end
                S_RESP: begin
                    ready_q <= 1'b1;
                    err_q   <= !mapped;
                    if (!lat_we) rdata_q <= rd_data;
                    state   <= S_HOLD;
                end
                S_HOLD: begin
                    // Wait for the CPU to drop its request so a held CPU_MIO cannot retrigger.
                    if (!bus.CPU_MIO) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            // A CPU write into the timer region outranks a wrap on the same edge.
            if (tmr_wr && sel_period) begin
                period <= lat_data[TIMER_W-1:0];
                count  <= '0;
            end else if (wrap) begin
                count <= '0;
            end else if (running) begin
                count <= count + TIMER_W'(1);
            end

            if (tmr_wr && sel_ctrl) enable <= lat_data[0];

            if (wrap && !tmr_wr)  irq_q <= 1'b1;
            else if (bus.int_ack) irq_q <= 1'b0;
        end
    end

    assign bus.MIO_ready = ready_q;
    assign bus.bus_err   = err_q;
    assign bus.Data_in   = rdata_q;
    assign bus.INT       = irq_q;
endmodule

// File: tb/tb_mio_wait_target.sv
// Self-checking bench for mio_wait_target: randomized RAM traffic against an address-map model,
// plus directed timer, interrupt, unmapped-access and reset-abort scenarios.
module tb_mio_wait_target;
    localparam int DATA_W      = 32;
    localparam int ADDR_W      = 32;
    localparam int DEPTH_LOG2  = 10;
    localparam int WAIT_CYCLES = 2;
    localparam int TIMER_W     = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    mio_wait_target_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mio_wait_target #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH_LOG2(DEPTH_LOG2),
        .WAIT_CYCLES(WAIT_CYCLES), .TIMER_W(TIMER_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    // Reference model: RAM words by index, timer count derived arithmetically from the
    // edge of the last event that changed it.
    logic [31:0] mem_model [int];
    int tm_per, tm_en, tm_ref_cyc, tm_ref_cnt;

    function automatic int tm_count_at(input int c);
        if (tm_en == 0 || tm_per == 0) return tm_ref_cnt;
        return (tm_ref_cnt + c - tm_ref_cyc) % tm_per;
    endfunction

    task automatic model_reset();
        tm_per = 0; tm_en = 0; tm_ref_cyc = 0; tm_ref_cnt = 0;
    endtask

    task automatic model_access(input bit we, input logic [31:0] a, input logic [31:0] d,
                                input int c, output logic [31:0] exp_rd, output bit exp_err,
                                output bit known);
        int w;
        exp_rd = '0; exp_err = 1'b0; known = 1'b1;
        if (a[31:28] == 4'hF) begin
            case (a[27:0] & 28'hFFF_FFFC)
                28'h0: if (we) begin tm_per = int'(d[15:0]); tm_ref_cyc = c; tm_ref_cnt = 0; end
                       else exp_rd = tm_per;
                28'h4: if (we) begin tm_ref_cnt = tm_count_at(c); tm_ref_cyc = c; tm_en = int'(d[0]); end
                       else exp_rd = tm_en;
                28'h8: if (!we) exp_rd = tm_count_at(c - 1);
                default: exp_err = 1'b1;
            endcase
        end else if ((a >> (DEPTH_LOG2 + 2)) == 0) begin
            w = int'(a[DEPTH_LOG2+1:2]);
            if (we) mem_model[w] = d;
            else if (mem_model.exists(w)) exp_rd = mem_model[w];
            else known = 1'b0;
        end else begin
            exp_err = 1'b1;
        end
    endtask

    // One complete bus access; request fields are scrambled after acceptance.
    task automatic xfer(input bit we, input logic [31:0] a, input logic [31:0] d, input int hold_extra,
                        output logic [31:0] rdata, output bit err, output int lat,
                        output int commit, output int extra_ready);
        int acc;
        bus.CPU_MIO = 1'b1; bus.mem_w = we; bus.Addr_out = a; bus.Data_out = d;
        @(posedge clk); #1;
        acc = cyc;
        bus.mem_w = 1'($urandom); bus.Addr_out = $urandom; bus.Data_out = $urandom;
        lat = -1; commit = cyc; rdata = '0; err = 1'b0;
        for (int i = 0; i < 20 && lat < 0; i++) begin
            @(posedge clk); #1;
            if (bus.MIO_ready === 1'b1) begin
                lat = cyc - acc; commit = cyc; rdata = bus.Data_in; err = bus.bus_err;
            end
        end
        extra_ready = 0;
        for (int i = 0; i < hold_extra + 1; i++) begin
            @(posedge clk); #1;
            if (bus.MIO_ready !== 1'b0) extra_ready++;
        end
        bus.CPU_MIO = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({bus.MIO_ready, bus.bus_err, bus.INT} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got ready/err/int=%b expected 000",
                               {bus.MIO_ready, bus.bus_err, bus.INT});
        end
        n_tests++;
        if (bus.Data_in !== 32'h0) begin
            n_fail++; $display("FAIL reset_data_in: got %h expected 00000000", bus.Data_in);
        end
        reset = 1'b1;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_read_latency();
        logic [31:0] rd; bit err; int lat, cm, ex;
        xfer(1'b0, 32'h0000_0010, 32'h0, 0, rd, err, lat, cm, ex);
        n_tests++;
        if (lat !== WAIT_CYCLES + 1) begin
            n_fail++; $display("FAIL read_latency: got %0d expected %0d", lat, WAIT_CYCLES + 1);
        end
        n_tests++;
        if (ex !== 0 || err !== 1'b0) begin
            n_fail++; $display("FAIL read_pulse: extra_ready=%0d err=%b expected 0 and 0", ex, err);
        end
    endtask

    task automatic test_write_read();
        logic [31:0] rd, exp_rd; bit err, exp_err, known; int lat, cm, ex;
        xfer(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 0, rd, err, lat, cm, ex);
        model_access(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, cm, exp_rd, exp_err, known);
        n_tests++;
        if (err !== exp_err || lat !== WAIT_CYCLES + 1) begin
            n_fail++; $display("FAIL write_resp: err=%b lat=%0d expected err=%b lat=%0d",
                               err, lat, exp_err, WAIT_CYCLES + 1);
        end
        xfer(1'b0, 32'h0000_0040, 32'h0, 5, rd, err, lat, cm, ex);
        model_access(1'b0, 32'h0000_0040, 32'h0, cm, exp_rd, exp_err, known);
        n_tests++;
        if (rd !== exp_rd) begin
            n_fail++; $display("FAIL write_read_data: got %h expected %h", rd, exp_rd);
        end
        n_tests++;
        if (ex !== 0) begin
            n_fail++; $display("FAIL held_request_retrigger: got %0d extra ready cycles expected 0", ex);
        end
    endtask

    task automatic test_random_ram();
        logic [31:0] a, d, rd, exp_rd; bit we, err, exp_err, known; int lat, cm, ex;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0)
                a = ($urandom_range(1, 32'h000E_FFFF) << 12) | ($urandom & 32'hFFF);
            else
                a = ($urandom_range(0, 63) << 2) | ($urandom & 32'h3);
            we = 1'($urandom);
            d  = $urandom;
            xfer(we, a, d, int'($urandom_range(0, 3)), rd, err, lat, cm, ex);
            model_access(we, a, d, cm, exp_rd, exp_err, known);
            n_tests++;
            if (lat !== WAIT_CYCLES + 1 || ex !== 0 || err !== exp_err) begin
                n_fail++; $display("FAIL random_resp[%0d] addr=%h: lat=%0d extra=%0d err=%b expected lat=%0d extra=0 err=%b",
                                   i, a, lat, ex, err, WAIT_CYCLES + 1, exp_err);
            end
            if (!we && known) begin
                n_tests++;
                if (rd !== exp_rd) begin
                    n_fail++; $display("FAIL random_read[%0d] addr=%h: got %h expected %h", i, a, rd, exp_rd);
                end
            end
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] rd, exp_rd; bit err, exp_err, known; int lat, cm, ex;
        xfer(1'b1, 32'h0000_0000, 32'h0BAD_F00D, 0, rd, err, lat, cm, ex);
        model_access(1'b1, 32'h0000_0000, 32'h0BAD_F00D, cm, exp_rd, exp_err, known);
        xfer(1'b1, 32'h0010_0000, 32'h1234_5678, 0, rd, err, lat, cm, ex);
        model_access(1'b1, 32'h0010_0000, 32'h1234_5678, cm, exp_rd, exp_err, known);
        n_tests++;
        if (err !== 1'b1 || lat !== WAIT_CYCLES + 1) begin
            n_fail++; $display("FAIL unmapped_write_err: err=%b lat=%0d expected 1 and %0d", err, lat, WAIT_CYCLES + 1);
        end
        xfer(1'b0, 32'h0000_0000, 32'h0, 0, rd, err, lat, cm, ex);
        model_access(1'b0, 32'h0000_0000, 32'h0, cm, exp_rd, exp_err, known);
        n_tests++;
        if (rd !== exp_rd || err !== 1'b0) begin
            n_fail++; $display("FAIL unmapped_no_alias: word0=%h err=%b expected %h err=0", rd, err, exp_rd);
        end
        xfer(1'b0, 32'h0010_0000, 32'h0, 0, rd, err, lat, cm, ex);
        n_tests++;
        if (rd !== 32'h0 || err !== 1'b1) begin
            n_fail++; $display("FAIL unmapped_read: got %h err=%b expected 00000000 err=1", rd, err);
        end
        xfer(1'b0, 32'hF000_000C, 32'h0, 0, rd, err, lat, cm, ex);
        n_tests++;
        if (rd !== 32'h0 || err !== 1'b1) begin
            n_fail++; $display("FAIL timer_bad_offset: got %h err=%b expected 00000000 err=1", rd, err);
        end
    endtask

    task automatic test_timer_fire_ack();
        logic [31:0] rd, exp_rd; bit err, exp_err, known; int lat, cm, ex, ce, rise, lows, c0;
        xfer(1'b1, 32'hF000_0000, 32'd5, 0, rd, err, lat, cm, ex);
        model_access(1'b1, 32'hF000_0000, 32'd5, cm, exp_rd, exp_err, known);
        xfer(1'b1, 32'hF000_0004, 32'd1, 0, rd, err, lat, cm, ex);
        model_access(1'b1, 32'hF000_0004, 32'd1, cm, exp_rd, exp_err, known);
        ce = cm;
        rise = -1;
        for (int i = 0; i < 40 && rise < 0; i++) begin
            if (bus.INT === 1'b1) rise = cyc;
            else begin @(posedge clk); #1; end
        end
        n_tests++;
        if (rise !== ce + 5) begin
            n_fail++; $display("FAIL int_rise: INT rose after edge %0d expected %0d", rise, ce + 5);
        end
        lows = 0;
        repeat (7) begin @(posedge clk); #1; if (bus.INT !== 1'b1) lows++; end
        n_tests++;
        if (lows !== 0) begin
            n_fail++; $display("FAIL int_sticky: INT low for %0d cycles expected 0", lows);
        end
        if ((cyc + 1 - ce) % 5 == 0) begin @(posedge clk); #1; end
        bus.int_ack = 1'b1; @(posedge clk); #1; bus.int_ack = 1'b0;
        n_tests++;
        if (bus.INT !== 1'b0) begin
            n_fail++; $display("FAIL int_ack_clear: got %b expected 0", bus.INT);
        end
        for (int i = 0; i < 10 && (cyc + 1 - ce) % 5 != 0; i++) begin @(posedge clk); #1; end
        bus.int_ack = 1'b1; @(posedge clk); #1; bus.int_ack = 1'b0;
        n_tests++;
        if (bus.INT !== 1'b1) begin
            n_fail++; $display("FAIL int_set_beats_ack: got %b expected 1", bus.INT);
        end
        // Line up a control write to commit on a wrap edge, with INT cleared just before.
        for (int i = 0; i < 10 && (cyc - ce) % 5 != 0; i++) begin @(posedge clk); #1; end
        c0 = cyc;
        bus.int_ack = 1'b1; @(posedge clk); #1; bus.int_ack = 1'b0;
        xfer(1'b1, 32'hF000_0004, 32'd1, 0, rd, err, lat, cm, ex);
        model_access(1'b1, 32'hF000_0004, 32'd1, cm, exp_rd, exp_err, known);
        n_tests++;
        if (cm !== c0 + 5 || bus.INT !== 1'b0) begin
            n_fail++; $display("FAIL write_beats_wrap: commit edge %0d INT=%b expected edge %0d INT=0",
                               cm, bus.INT, c0 + 5);
        end
        xfer(1'b0, 32'hF000_0008, 32'h0, 0, rd, err, lat, cm, ex);
        model_access(1'b0, 32'hF000_0008, 32'h0, cm, exp_rd, exp_err, known);
        n_tests++;
        if (rd !== exp_rd || err !== 1'b0) begin
            n_fail++; $display("FAIL count_read: got %h err=%b expected %h err=0", rd, err, exp_rd);
        end
        xfer(1'b0, 32'hF000_0000, 32'h0, 0, rd, err, lat, cm, ex);
        model_access(1'b0, 32'hF000_0000, 32'h0, cm, exp_rd, exp_err, known);
        n_tests++;
        if (rd !== exp_rd) begin
            n_fail++; $display("FAIL period_read: got %h expected %h", rd, exp_rd);
        end
    endtask

    task automatic test_period_zero_freeze();
        logic [31:0] rd, exp_rd; bit err, exp_err, known; int lat, cm, ex, highs;
        xfer(1'b1, 32'hF000_0000, 32'd0, 0, rd, err, lat, cm, ex);
        model_access(1'b1, 32'hF000_0000, 32'd0, cm, exp_rd, exp_err, known);
        bus.int_ack = 1'b1; @(posedge clk); #1; bus.int_ack = 1'b0;
        highs = 0;
        repeat (100) begin @(posedge clk); #1; if (bus.INT !== 1'b0) highs++; end
        n_tests++;
        if (highs !== 0) begin
            n_fail++; $display("FAIL period_zero_int: INT high %0d cycles expected 0", highs);
        end
        xfer(1'b0, 32'hF000_0008, 32'h0, 0, rd, err, lat, cm, ex);
        model_access(1'b0, 32'hF000_0008, 32'h0, cm, exp_rd, exp_err, known);
        n_tests++;
        if (rd !== exp_rd) begin
            n_fail++; $display("FAIL period_zero_count: got %h expected %h", rd, exp_rd);
        end
        xfer(1'b1, 32'hF000_0000, 32'd100, 0, rd, err, lat, cm, ex);
        model_access(1'b1, 32'hF000_0000, 32'd100, cm, exp_rd, exp_err, known);
        repeat ($urandom_range(0, 20)) @(posedge clk);
        #1;
        xfer(1'b1, 32'hF000_0004, 32'd0, 0, rd, err, lat, cm, ex);
        model_access(1'b1, 32'hF000_0004, 32'd0, cm, exp_rd, exp_err, known);
        for (int k = 0; k < 2; k++) begin
            repeat ($urandom_range(1, 15)) @(posedge clk);
            #1;
            xfer(1'b0, 32'hF000_0008, 32'h0, 0, rd, err, lat, cm, ex);
            model_access(1'b0, 32'hF000_0008, 32'h0, cm, exp_rd, exp_err, known);
            n_tests++;
            if (rd !== exp_rd) begin
                n_fail++; $display("FAIL frozen_count[%0d]: got %h expected %h", k, rd, exp_rd);
            end
        end
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] rd, exp_rd; bit err, exp_err, known; int lat, cm, ex, readies;
        xfer(1'b1, 32'h0000_0020, 32'h1357_9BDF, 0, rd, err, lat, cm, ex);
        model_access(1'b1, 32'h0000_0020, 32'h1357_9BDF, cm, exp_rd, exp_err, known);
        bus.CPU_MIO = 1'b1; bus.mem_w = 1'b1; bus.Addr_out = 32'h0000_0020; bus.Data_out = 32'hAAAA_5555;
        @(posedge clk); #1;
        reset = 1'b0; bus.CPU_MIO = 1'b0;
        readies = 0;
        repeat (3) begin @(posedge clk); #1; if (bus.MIO_ready !== 1'b0) readies++; end
        reset = 1'b1;
        model_reset();
        repeat (5) begin @(posedge clk); #1; if (bus.MIO_ready !== 1'b0) readies++; end
        n_tests++;
        if (readies !== 0 || bus.INT !== 1'b0) begin
            n_fail++; $display("FAIL reset_abort: ready cycles=%0d INT=%b expected 0 and 0", readies, bus.INT);
        end
        xfer(1'b0, 32'h0000_0020, 32'h0, 0, rd, err, lat, cm, ex);
        model_access(1'b0, 32'h0000_0020, 32'h0, cm, exp_rd, exp_err, known);
        n_tests++;
        if (rd !== exp_rd) begin
            n_fail++; $display("FAIL reset_no_commit: got %h expected %h", rd, exp_rd);
        end
        xfer(1'b0, 32'hF000_0000, 32'h0, 0, rd, err, lat, cm, ex);
        model_access(1'b0, 32'hF000_0000, 32'h0, cm, exp_rd, exp_err, known);
        n_tests++;
        if (rd !== exp_rd) begin
            n_fail++; $display("FAIL reset_period: got %h expected %h", rd, exp_rd);
        end
    endtask

    initial begin
        bus.CPU_MIO = 1'b0; bus.mem_w = 1'b0; bus.Addr_out = '0; bus.Data_out = '0; bus.int_ack = 1'b0;
        model_reset();
        test_reset();
        test_read_latency();
        test_write_read();
        test_random_ram();
        test_unmapped();
        test_timer_fire_ack();
        test_period_zero_freeze();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
